// File: rtl/reg_file_dumper.sv
// Debug read-out initiator: freezes the core, reads a register range through the
// reg_file's two asynchronous read ports, and streams each register on a valid/ready port.
module reg_file_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic                  stall_req,
  input  logic                  core_stalled,
  output logic [ADDR_WIDTH-1:0] rf_read_reg1,
  output logic [ADDR_WIDTH-1:0] rf_read_reg2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_STALL = 3'd1,
    READ       = 3'd2,
    SEND0      = 3'd3,
    SEND1      = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   lst_q, lst_d;
  logic [DATA_WIDTH-1:0]   buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   idx_nxt;

  // Second read port always points one past idx; wraps to 0 at the top (value unused then).
  assign idx_nxt = idx_q + ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lst_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lst_q   <= lst_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lst_d        = lst_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    err_d        = 1'b0;
    stall_req    = 1'b0;
    rf_read_reg1 = '0;
    rf_read_reg2 = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_index    = '0;
    out_last     = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            idx_d   = first_reg;
            lst_d   = last_reg;
            state_d = WAIT_STALL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_STALL: begin
        stall_req = 1'b1;
        if (core_stalled) state_d = READ;
      end
      READ: begin
        stall_req    = 1'b1;
        rf_read_reg1 = idx_q;
        rf_read_reg2 = idx_nxt;
        buf0_d       = rf_read_data1;
        buf1_d       = rf_read_data2;
        state_d      = SEND0;
      end
      SEND0: begin
        stall_req = 1'b1;
        out_valid = 1'b1;
        out_data  = buf0_q;
        out_index = idx_q;
        out_last  = (idx_q == lst_q);
        if (out_ready) state_d = (idx_q == lst_q) ? DONE : SEND1;
      end
      SEND1: begin
        stall_req = 1'b1;
        out_valid = 1'b1;
        out_data  = buf1_q;
        out_index = idx_nxt;
        out_last  = (idx_nxt == lst_q);
        if (out_ready) begin
          if (idx_nxt == lst_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + TWO;
            state_d = READ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper with a behavioural register file on the read ports.
module tb_reg_file_dumper;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_reg, last_reg;
  logic          stall_req, core_stalled;
  logic [AW-1:0] rf_read_reg1, rf_read_reg2;
  logic [DW-1:0] rf_read_data1, rf_read_data2;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last, busy, done, err;

  logic [DW-1:0] regs [32];

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] last_word;

  always #5 clk = ~clk;

  assign rf_read_data1 = regs[rf_read_reg1];
  assign rf_read_data2 = regs[rf_read_reg2];

  reg_file_dumper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .stall_req(stall_req), .core_stalled(core_stalled),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_stall"}, stall_req, 0);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_err"},   err, 0);
    check_eq({tag, "_rf"},    {rf_read_reg1, rf_read_reg2}, 0);
    check_eq({tag, "_data"},  {out_data, out_index, out_last}, 0);
  endtask

  // Entered one cycle after start was accepted (state WAIT_STALL, core_stalled already 1).
  // t counts cycles from that point; bp toggles out_ready; exp_done_t < 0 skips timing check.
  task automatic dump_check(input int f, input int l, input bit bp, input int exp_done_t,
                            input int probe_t, input int probe_r1, input int probe_r2);
    int exp_i = f;
    int words = 0;
    bit held = 1'b0;
    bit got_done = 1'b0;
    logic [DW-1:0] h_data;
    logic [AW-1:0] h_index;
    logic          h_last;
    for (int t = 0; t < 300; t++) begin
      out_ready = bp ? t[0] : 1'b1;
      if (t == 2) begin
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd31;
      end else begin
        start = 1'b0;
      end
      if (t == probe_t) check_eq("read_ports", {rf_read_reg1, rf_read_reg2}, {probe_r1[AW-1:0], probe_r2[AW-1:0]});
      if (held) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_word", {out_data, out_index, out_last}, {h_data, h_index, h_last});
      end
      if (out_valid) begin
        check_eq("word_index", out_index, exp_i[AW-1:0]);
        check_eq("word_data",  out_data, regs[exp_i]);
        check_eq("word_last",  out_last, (exp_i == l));
        check_eq("stall_send", stall_req, 1);
        if (out_ready) begin
          last_word = out_data;
          exp_i++;
          words++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          h_data = out_data; h_index = out_index; h_last = out_last;
        end
      end
      if (done) begin
        got_done = 1'b1;
        check_eq("done_stall", stall_req, 0);
        check_eq("done_valid", out_valid, 0);
        check_eq("word_count", words, l - f + 1);
        if (exp_done_t >= 0) check_eq("done_time", t, exp_done_t);
        step();
        check_eq("after_done", {done, busy}, 0);
        break;
      end
      step();
    end
    if (!got_done) check_eq("done_timeout", 0, 1);
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic kick(input int f, input int l);
    start = 1'b1; first_reg = f[AW-1:0]; last_reg = l[AW-1:0];
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    reset = 1'b0; start = 1'b1; first_reg = 5'd0; last_reg = 5'd3;
    core_stalled = 1'b1; out_ready = 1'b1;
    step(); step();
    check_idle_outputs("reset");
    reset = 1'b1; start = 1'b0;
    step();
    check_idle_outputs("post_reset");

    // Single register: 1 word, READ at t=1, SEND0 at t=2, DONE at t=3
    regs[5] = 32'hDEADBEEF;
    kick(5, 5);
    check_eq("single_stall", {busy, stall_req}, 2'b11);
    dump_check(5, 5, 1'b0, 3, 1, 5, 6);
    check_eq("single_word", last_word, 32'hDEADBEEF);

    // Odd range with backpressure
    regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33;
    kick(1, 3);
    dump_check(1, 3, 1'b1, -1, 1, 1, 2);
    check_eq("odd_last_word", last_word, 32'h33);

    // Full dump: done one cycle after the 48-cycle streaming window starting at t=1
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;
    kick(0, 31);
    dump_check(0, 31, 1'b0, 49, 46, 30, 31);
    check_eq("full_last_word", last_word, 32'h1F1F1F1F);

    // Top register: second read port wraps to 0
    kick(31, 31);
    dump_check(31, 31, 1'b0, 3, 1, 31, 0);

    // Stall handshake: nothing read or sent until core_stalled rises
    core_stalled = 1'b0;
    kick(2, 3);
    for (int k = 0; k < 10; k++) begin
      check_eq("wait_stall_req", stall_req, 1);
      check_eq("wait_no_read", {rf_read_reg1, rf_read_reg2, out_valid}, 0);
      step();
    end
    core_stalled = 1'b1;
    dump_check(2, 3, 1'b0, 4, 1, 2, 3);

    // Rejected start
    kick(9, 4);
    check_eq("err_pulse", {err, busy}, 2'b10);
    step();
    check_eq("err_clear", {err, busy}, 2'b00);

    // Reset in SEND1: t0 WAIT, t1 READ, t2 SEND0, t3 SEND1
    kick(1, 3);
    step(); step(); step();
    check_eq("in_send1", {out_valid, out_index}, {1'b1, 5'd2});
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_idle_outputs("mid_reset");
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("abandon", {done, out_valid, busy}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
